// File: rtl/fir_acc_mc.sv
// Multi-channel FIR accumulator: CH saturating accumulators with sticky overflow, plus a
// round/scale/saturate dump path feeding a small valid/ready output FIFO.
module fir_acc_mc #(
    parameter int IN_W     = 21,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16,
    parameter int CH       = 2,
    parameter int SHIFT    = 8,
    parameter int ROUND    = 1,
    parameter int DUMP_CLR = 0,
    parameter int FIFO_D   = 2,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk_b,
    input  logic                    rst,
    input  logic                    acc_clr,
    input  logic                    acc_load,
    input  logic                    acc_en,
    input  logic [CH_W-1:0]         acc_ch,
    input  logic signed [IN_W-1:0]  acc_in,
    input  logic                    dump,
    input  logic [CH_W-1:0]         dump_ch,
    output logic                    dump_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_ovf,
    output logic                    drop_err
);

    localparam int PW  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW  = $clog2(FIFO_D + 1);
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACC_W:0] RndAdd =
        (ROUND != 0 && SHIFT > 0) ? (ACC_W + 1)'(1) << RSH : '0;
    localparam logic signed [ACC_W:0] AccMax = {2'b00, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] AccMin = {2'b11, {(ACC_W - 1){1'b0}}};
    localparam logic signed [ACC_W:0] OutMax = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OutMin = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] acc_q [CH];
    logic signed [ACC_W-1:0] acc_d [CH];
    logic [CH-1:0]           ovf_q, ovf_d;

    logic signed [OUT_W-1:0] fd_q [FIFO_D];
    logic [CH_W-1:0]         fc_q [FIFO_D];
    logic [FIFO_D-1:0]       fo_q;
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q;
    logic                    drop_q, drop_d;

    logic                    upd_ok, dump_ok, full, push, pop;
    logic signed [ACC_W-1:0] dump_acc, base;
    logic                    dump_ovf, base_ovf, sat_ovf;
    logic signed [ACC_W:0]   rnd_sum, shf, add_sum;
    logic signed [OUT_W-1:0] scaled;

    assign upd_ok  = 32'(acc_ch) < CH;
    assign dump_ok = dump && (32'(dump_ch) < CH);
    assign full    = cnt_q == CW'(FIFO_D);
    assign push    = dump_ok && !full;
    assign pop     = out_valid && out_ready;

    // Dump path reads the pre-update register value.
    always_comb begin
        dump_acc = dump_ok ? acc_q[dump_ch] : '0;
        dump_ovf = dump_ok ? ovf_q[dump_ch] : 1'b0;
        rnd_sum  = (ACC_W + 1)'(dump_acc) + RndAdd;
        shf      = rnd_sum >>> SHIFT;
        sat_ovf  = 1'b0;
        if (shf > OutMax) begin
            scaled  = OutMax[OUT_W-1:0];
            sat_ovf = 1'b1;
        end else if (shf < OutMin) begin
            scaled  = OutMin[OUT_W-1:0];
            sat_ovf = 1'b1;
        end else begin
            scaled = shf[OUT_W-1:0];
        end
    end

    always_comb begin
        base     = '0;
        base_ovf = 1'b0;
        add_sum  = '0;
        for (int c = 0; c < CH; c++) begin
            base     = acc_q[c];
            base_ovf = ovf_q[c];
            // Clear-on-dump happens first so a same-cycle en degenerates to a load.
            if (push && DUMP_CLR != 0 && dump_ch == CH_W'(c)) begin
                base     = '0;
                base_ovf = 1'b0;
            end
            acc_d[c] = base;
            ovf_d[c] = base_ovf;
            if (upd_ok && acc_ch == CH_W'(c)) begin
                if (acc_load) begin
                    acc_d[c] = ACC_W'(acc_in);
                    ovf_d[c] = 1'b0;
                end else if (acc_en) begin
                    add_sum = (ACC_W + 1)'(base) + (ACC_W + 1)'(acc_in);
                    if (add_sum > AccMax) begin
                        acc_d[c] = AccMax[ACC_W-1:0];
                        ovf_d[c] = 1'b1;
                    end else if (add_sum < AccMin) begin
                        acc_d[c] = AccMin[ACC_W-1:0];
                        ovf_d[c] = 1'b1;
                    end else begin
                        acc_d[c] = add_sum[ACC_W-1:0];
                    end
                end
            end
            if (acc_clr) begin
                acc_d[c] = '0;
                ovf_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        drop_d = acc_clr ? 1'b0 : drop_q;
        if (dump_ok && full) drop_d = 1'b1;
    end

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) acc_q[c] <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fd_q[i] <= '0;
                fc_q[i] <= '0;
            end
            ovf_q  <= '0;
            fo_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            if (push) begin
                fd_q[wr_q] <= scaled;
                fc_q[wr_q] <= dump_ch;
                fo_q[wr_q] <= dump_ovf | sat_ovf;
                wr_q       <= (wr_q == PW'(FIFO_D - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop) rd_q <= (rd_q == PW'(FIFO_D - 1)) ? '0 : rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign dump_ready = !full;
    assign out_valid  = cnt_q != '0;
    assign out_data   = out_valid ? fd_q[rd_q] : '0;
    assign out_ch     = out_valid ? fc_q[rd_q] : '0;
    assign out_ovf    = out_valid ? fo_q[rd_q] : 1'b0;
    assign drop_err   = drop_q;

endmodule
